// File: rtl/square_accum_pkg.sv
// rtl/square_accum_pkg.sv - shared types and width helpers for the square accumulation scheduler
package square_accum_pkg;

    // Widest channel index the scheduler supports (NCHAN up to 16).
    localparam int CHW_MAX = 4;

    // Tag travelling alongside each square through the squarer latency.
    typedef struct packed {
        logic               vld;
        logic [CHW_MAX-1:0] chan;
    } tag_t;

    // Result register occupancy.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // A square of an 8-bit signed value needs 15 bits; NSAMP of them add log2(NSAMP).
    function automatic int acc_bits(input int nsamp);
        return 15 + $clog2(nsamp);
    endfunction

endpackage

// File: rtl/signed_8b_square.sv
// rtl/signed_8b_square.sv - pipelined square of a signed 8-bit value, LATENCY clocks in_i to out_o
module signed_8b_square #(
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic signed [7:0] in_i,
    output logic [14:0]       out_o
);

    logic [7:0]  mag;
    logic [14:0] mag_ext;
    logic [14:0] pipe [LATENCY];

    // Magnitude of -128 is 128, which is still representable unsigned in 8 bits.
    assign mag     = in_i[7] ? 8'(-in_i) : in_i;
    assign mag_ext = {7'b0, mag};

    // Square in the first stage, then delay to the requested latency.
    always_ff @(posedge clk_i) begin
        pipe[0] <= mag_ext * mag_ext;
        for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign out_o = pipe[LATENCY-1];

endmodule

// File: rtl/square_accum_sched_rr_arb.sv
// rtl/square_accum_sched_rr_arb.sv - N-way round-robin arbiter with one-hot grant and index
module rr_arb #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;

    // Scan requests starting from the priority pointer; first hit wins.
    always_comb begin
        int            idx;
        logic          found;
        logic [IW-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IW'(idx);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
                found      = 1'b1;
            end
        end
    end

    // Priority moves to the channel after the one just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && |req) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/square_accum_sched.sv
// rtl/square_accum_sched.sv - shares one squarer among NCHAN streams, emits per-channel power sums (option: SQUARE_ACCUM_CHECK_EN)
module square_accum_sched
    import square_accum_pkg::*;
#(
    parameter  int NCHAN      = 4,
    parameter  int NSAMP      = 16,
    parameter  int SQ_LATENCY = 2,
    localparam int ACC_BITS   = acc_bits(NSAMP),
    localparam int CHW        = $clog2(NCHAN)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [8*NCHAN-1:0]   dat_i,
    input  logic [NCHAN-1:0]     valid_i,
    output logic [NCHAN-1:0]     ready_o,
    output logic [ACC_BITS-1:0]  pwr_o,
    output logic [CHW-1:0]       pwr_chan_o,
    output logic                 pwr_valid_o,
    input  logic                 pwr_ready_i
`ifdef SQUARE_ACCUM_CHECK_EN
    ,
    output logic                 err_o
`endif
);

    localparam int CW = $clog2(NSAMP) + 1;

    logic [NCHAN-1:0]    elig;
    logic [NCHAN-1:0]    issue_gnt;
    logic [CHW-1:0]      issue_idx;
    logic [NCHAN-1:0]    done_q;
    logic [NCHAN-1:0]    pick_gnt;
    logic [CHW-1:0]      pick_idx;
    logic                load;
    logic [CW-1:0]       issue_cnt [NCHAN];
    logic [CW-1:0]       cmp_cnt   [NCHAN];
    logic [ACC_BITS-1:0] acc       [NCHAN];
    tag_t                tag_q     [SQ_LATENCY];
    tag_t                tag_exit;
    logic [7:0]          sq_in;
    logic [14:0]         sq_out;
    out_state_t          out_state;

    // A channel may issue while it has window space and no finished sum waiting.
    always_comb begin
        elig = '0;
        for (int n = 0; n < NCHAN; n++) begin
            elig[n] = ~rst_i & valid_i[n] & (issue_cnt[n] < CW'(NSAMP)) & ~done_q[n];
        end
    end

    rr_arb #(.N(NCHAN)) u_issue_arb (
        .clk       (clk_i),
        .rst       (rst_i),
        .req       (elig),
        .advance   (1'b1),
        .grant     (issue_gnt),
        .grant_idx (issue_idx)
    );

    assign ready_o = issue_gnt;

    // Route the granted channel's sample into the squarer this cycle.
    always_comb begin
        sq_in = '0;
        for (int n = 0; n < NCHAN; n++) begin
            if (issue_gnt[n]) begin
                sq_in = dat_i[8*n +: 8];
            end
        end
    end

    signed_8b_square #(.LATENCY(SQ_LATENCY)) u_square (
        .clk_i (clk_i),
        .in_i  (sq_in),
        .out_o (sq_out)
    );

    // Tag shift register matches the squarer latency so out_o knows its owner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SQ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: |issue_gnt, chan: CHW_MAX'(issue_idx)};
            for (int i = 1; i < SQ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_exit = tag_q[SQ_LATENCY-1];

    // Output may take a new sum when empty or when the current one is being accepted.
    assign load = (|done_q) & ((out_state == OUT_EMPTY) | pwr_ready_i);

    rr_arb #(.N(NCHAN)) u_pick_arb (
        .clk       (clk_i),
        .rst       (rst_i),
        .req       (done_q),
        .advance   (load),
        .grant     (pick_gnt),
        .grant_idx (pick_idx)
    );

    // Per-channel issue count, accumulation and completion; a load frees the channel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q <= '0;
            for (int n = 0; n < NCHAN; n++) begin
                issue_cnt[n] <= '0;
                cmp_cnt[n]   <= '0;
                acc[n]       <= '0;
            end
        end else begin
            for (int n = 0; n < NCHAN; n++) begin
                if (issue_gnt[n]) begin
                    issue_cnt[n] <= issue_cnt[n] + 1'b1;
                end
                if (tag_exit.vld && tag_exit.chan == CHW_MAX'(n)) begin
                    acc[n]     <= acc[n] + ACC_BITS'(sq_out);
                    cmp_cnt[n] <= cmp_cnt[n] + 1'b1;
                    if (cmp_cnt[n] == CW'(NSAMP - 1)) begin
                        done_q[n] <= 1'b1;
                    end
                end
                if (load && pick_gnt[n]) begin
                    issue_cnt[n] <= '0;
                    cmp_cnt[n]   <= '0;
                    acc[n]       <= '0;
                    done_q[n]    <= 1'b0;
                end
            end
        end
    end

    // Result register: EMPTY/FULL with same-cycle reload on accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_state   <= OUT_EMPTY;
            pwr_valid_o <= 1'b0;
            pwr_o       <= '0;
            pwr_chan_o  <= '0;
        end else if (load) begin
            out_state   <= OUT_FULL;
            pwr_valid_o <= 1'b1;
            pwr_o       <= acc[pick_idx];
            pwr_chan_o  <= pick_idx;
        end else if (out_state == OUT_FULL && pwr_ready_i) begin
            out_state   <= OUT_EMPTY;
            pwr_valid_o <= 1'b0;
        end
    end

`ifdef SQUARE_ACCUM_CHECK_EN
    logic [7:0]         smp_q [SQ_LATENCY];
    logic signed [15:0] smp_ext;
    logic signed [15:0] ref_sq;

    assign smp_ext = {{8{smp_q[SQ_LATENCY-1][7]}}, smp_q[SQ_LATENCY-1]};
    assign ref_sq  = smp_ext * smp_ext;

    // Issued samples ride alongside the tags so each square can be re-derived.
    always_ff @(posedge clk_i) begin
        smp_q[0] <= sq_in;
        for (int i = 1; i < SQ_LATENCY; i++) begin
            smp_q[i] <= smp_q[i-1];
        end
    end

    // Sticky flag on any squarer result that disagrees with the reference.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (tag_exit.vld && (ref_sq != {1'b0, sq_out})) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_square_accum_sched.sv
// tb/tb_square_accum_sched.sv - self-checking bench for square_accum_sched
module tb_square_accum_sched;

    localparam int NCH  = 4;
    localparam int NS   = 16;
    localparam int LAT  = 2;
    localparam int ACCW = 15 + $clog2(NS);

    logic            clk = 1'b0;
    logic            rst;
    logic [8*NCH-1:0] dat;
    logic [NCH-1:0]  valid;
    logic [NCH-1:0]  ready;
    logic [ACCW-1:0] pwr;
    logic [1:0]      pwr_chan;
    logic            pwr_valid;
    logic            pwr_ready;
`ifdef SQUARE_ACCUM_CHECK_EN
    logic            err;
`endif

    square_accum_sched #(.NCHAN(NCH), .NSAMP(NS), .SQ_LATENCY(LAT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .dat_i       (dat),
        .valid_i     (valid),
        .ready_o     (ready),
        .pwr_o       (pwr),
        .pwr_chan_o  (pwr_chan),
        .pwr_valid_o (pwr_valid),
        .pwr_ready_i (pwr_ready)
`ifdef SQUARE_ACCUM_CHECK_EN
        ,
        .err_o       (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int     chan;
        longint val;
    } res_t;

    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    res_t   exp_q[$];
    int     got_chan[$];
    longint got_val[$];
    int     got_cyc[$];
    int     acc_log[$];
    int     win_cnt   [NCH];
    longint win_sum   [NCH];
    int     acc_total [NCH];
    int     first_acc = -1;
    int     first_vld = -1;
    logic   prev_vld  = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: window sums from accepted samples, matched per channel at the output.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int n = 0; n < NCH; n++) begin
                win_cnt[n] = 0;
                win_sum[n] = 0;
                acc_total[n] = 0;
            end
            prev_vld = 1'b0;
        end else begin
            chk("ready_onehot", longint'($countones(ready) <= 1), 1);
            chk("ready_without_valid", longint'(ready & ~valid), 0);
            for (int n = 0; n < NCH; n++) begin
                if (ready[n] && valid[n]) begin
                    int     pend;
                    longint s;
                    pend = 0;
                    foreach (exp_q[i]) if (exp_q[i].chan == n) pend++;
                    chk("accept_while_blocked", longint'(pend >= 2), 0);
                    s = longint'($signed(dat[8*n +: 8]));
                    win_sum[n] += s * s;
                    win_cnt[n]++;
                    acc_total[n]++;
                    acc_log.push_back(n);
                    if (first_acc < 0) first_acc = cyc;
                    if (win_cnt[n] == NS) begin
                        exp_q.push_back('{chan: n, val: win_sum[n]});
                        win_cnt[n] = 0;
                        win_sum[n] = 0;
                    end
                end
            end
            if (pwr_valid) begin
                int idx;
                idx = -1;
                foreach (exp_q[i]) if (idx < 0 && exp_q[i].chan == int'(pwr_chan)) idx = i;
                chk("result_expected", longint'(idx >= 0), 1);
                if (idx >= 0) begin
                    chk("pwr_value", longint'(pwr), exp_q[idx].val);
                end
                if (!prev_vld && first_vld < 0) first_vld = cyc;
                if (pwr_ready) begin
                    if (idx >= 0) exp_q.delete(idx);
                    got_chan.push_back(int'(pwr_chan));
                    got_val.push_back(longint'(pwr));
                    got_cyc.push_back(cyc);
                end
            end
            prev_vld = pwr_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = '0;
        tick();
        tick();
        rst = 1'b0;
        got_chan.delete();
        got_val.delete();
        got_cyc.delete();
        acc_log.delete();
        first_acc = -1;
        first_vld = -1;
    endtask

    task automatic wait_got(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (got_val.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk(name, longint'(got_val.size() >= n), 1);
    endtask

    initial begin
        rst       = 1'b1;
        dat       = 32'h01020304;
        valid     = 4'hF;
        pwr_ready = 1'b1;
        tick();
        tick();
        chk("reset_ready", longint'(ready), 0);
        chk("reset_pwr_valid", longint'(pwr_valid), 0);
        chk("reset_pwr", longint'(pwr), 0);
        chk("reset_pwr_chan", longint'(pwr_chan), 0);
        do_reset();

        // Channel 0 alone at -128: full-scale sum and window latency.
        dat[7:0] = 8'h80;
        valid    = 4'b0001;
        wait_got(1, 100, "t1_timeout");
        valid = '0;
        chk("t1_chan", got_chan[0], 0);
        chk("t1_sum", got_val[0], 262144);
        chk("t1_latency", longint'(first_vld - first_acc), NS + LAT + 1);
        do_reset();

        // All channels, constant n+1: rotating grants and ordered results.
        dat   = {8'd4, 8'd3, 8'd2, 8'd1};
        valid = 4'hF;
        wait_got(4, 200, "t2_timeout");
        valid = '0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant_order", acc_log[i], i);
            chk("t2_chan", got_chan[i], i);
            chk("t2_sum", got_val[i], longint'((i + 1) * (i + 1) * NS));
        end
        do_reset();

        // Output blocked: channels stall full, then drain without bubbles.
        pwr_ready = 1'b0;
        dat   = {8'd8, 8'hF9, 8'd6, 8'hFB};
        valid = 4'hF;
        repeat (200) tick();
        chk("t3_stalled_ready", longint'(ready), 0);
        chk("t3_ch0_accepts", acc_total[0], 2 * NS);
        chk("t3_ch3_accepts", acc_total[3], NS);
        chk("t3_pending_valid", longint'(pwr_valid), 1);
        chk("t3_pending_chan", longint'(pwr_chan), 0);
        valid     = '0;
        pwr_ready = 1'b1;
        wait_got(5, 50, "t3_timeout");
        for (int i = 1; i < 5; i++) begin
            chk("t3_back_to_back", longint'(got_cyc[i] - got_cyc[i-1]), 1);
            chk("t3_drain_chan", got_chan[i], i % 4);
        end
        do_reset();

        // Sweep -128..127 on channel 2 in sixteen windows.
        for (int v = -128; v < 128; v++) begin
            int t;
            logic taken;
            dat[23:16] = 8'(v);
            valid      = 4'b0100;
            taken = 1'b0;
            t = 0;
            while (!taken && t < 20) begin
                @(negedge clk);
                taken = ready[2];
                tick();
                t++;
            end
            if (!taken) chk("t4_accept_timeout", v, -999);
        end
        valid = '0;
        wait_got(16, 100, "t4_timeout");
        chk("t4_first_window", got_val[0], 232664);
        chk("t4_last_window", got_val[15], 228824);
        chk("t4_chan", got_chan[15], 2);
`ifdef SQUARE_ACCUM_CHECK_EN
        chk("t4_err", longint'(err), 0);
`endif
        do_reset();

        // Reset with a pending result and squares in flight.
        pwr_ready = 1'b0;
        dat   = {4{8'd100}};
        valid = 4'hF;
        repeat (70) tick();
        chk("t5_pending_before_reset", longint'(pwr_valid), 1);
        rst   = 1'b1;
        valid = '0;
        tick();
        chk("t5_ready_zero", longint'(ready), 0);
        chk("t5_valid_zero", longint'(pwr_valid), 0);
        chk("t5_pwr_zero", longint'(pwr), 0);
        chk("t5_chan_zero", longint'(pwr_chan), 0);
        rst = 1'b0;
        got_chan.delete();
        got_val.delete();
        got_cyc.delete();
        pwr_ready = 1'b1;
        dat[7:0]  = 8'd3;
        valid     = 4'b0001;
        wait_got(1, 100, "t5_timeout");
        valid = '0;
        chk("t5_post_reset_sum", got_val[0], 144);
        do_reset();

        // Channel 1 with random valid; second window must stall behind a blocked output.
        pwr_ready = 1'b0;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 300; c++) begin
                dat[15:8] = 8'(3 * k - 40);
                valid     = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
                @(negedge clk);
                if (valid[1] && ready[1]) k++;
                tick();
            end
            valid = '0;
            chk("t6_accepted", k, 2 * NS);
        end
        chk("t6_pending_valid", longint'(pwr_valid), 1);
        pwr_ready = 1'b1;
        wait_got(2, 50, "t6_timeout");
        chk("t6_first_sum", got_val[0], 7960);
        chk("t6_second_sum", got_val[1], 17944);
        chk("t6_chan", got_chan[1], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
